branch_resolver: RTL and testbench

BRANCH_RESOLVER -- requirements
Module: branch_resolver

---
 rtl/branch_resolver_pkg.sv | 21 ++
 rtl/opcodes_pkg.sv | 14 +
 rtl/br_pred_queue.sv | 52 +++++
 rtl/branch_resolver.sv | 176 +++++++++++++++++
 tb/tb_branch_resolver.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/branch_resolver_pkg.sv
// Branch resolver types: prediction queue entry, FSM encoding, idle output values.
package branch_resolver_pkg;
  import opcodes_pkg::*;

  typedef struct packed {
    logic [WORD_SIZE-1:0] pc;
    logic [WORD_SIZE-1:0] pred_pc;
  } pred_entry_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } br_state_t;

  localparam logic [WORD_SIZE-1:0] BTB_INVALID = 16'hFFFF;

  function automatic logic is_branch(input logic [OPCODE_W-1:0] op);
    return (op == BNE_OP) || (op == BEQ_OP) || (op == BGZ_OP) || (op == BLZ_OP);
  endfunction

endpackage

// File: rtl/opcodes_pkg.sv
// Shared ISA definitions: datapath width and the resolver-relevant opcode encodings.
package opcodes_pkg;

  localparam int unsigned WORD_SIZE = 16;
  localparam int unsigned OPCODE_W  = 4;

  localparam logic [OPCODE_W-1:0] ADD_OP = 4'h0;
  localparam logic [OPCODE_W-1:0] SUB_OP = 4'h1;
  localparam logic [OPCODE_W-1:0] BEQ_OP = 4'h8;
  localparam logic [OPCODE_W-1:0] BNE_OP = 4'h9;
  localparam logic [OPCODE_W-1:0] BGZ_OP = 4'hA;
  localparam logic [OPCODE_W-1:0] BLZ_OP = 4'hB;

endpackage

// File: rtl/br_pred_queue.sv
// In-order FIFO of outstanding predictions; clear empties it in one cycle.
module br_pred_queue
  import branch_resolver_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  logic        clear,
  input  pred_entry_t push_data,
  output logic        full,
  output logic        empty,
  output pred_entry_t head
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  pred_entry_t   r_mem [DEPTH];
  logic          w_push;
  logic          w_pop;

  assign full   = (r_count == CW'(DEPTH));
  assign empty  = (r_count == '0);
  assign head   = r_mem[r_rd_ptr];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // DEPTH is a power of two, so the pointers wrap on their natural width
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !reset && !clear) r_mem[r_wr_ptr] <= push_data;
  end

endmodule

// File: rtl/branch_resolver.sv
// Resolves the oldest prediction, emits squash/BTB/counter pulses, squashes the queue.
// Optional: define BR_RESOLVER_STATS_EN to add branch/mispredict statistics outputs.
module branch_resolver
  import opcodes_pkg::*;
  import branch_resolver_pkg::*;
#(
  parameter int unsigned QDEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fetch_valid,
  input  logic [WORD_SIZE-1:0] fetch_pc,
  input  logic [WORD_SIZE-1:0] fetch_pred_pc,
  output logic                 fetch_ready,
  input  logic                 res_valid,
  input  logic [OPCODE_W-1:0]  res_opcode,
  input  logic                 res_bcond,
  input  logic [WORD_SIZE-1:0] res_target,
  output logic                 flush,
  output logic [WORD_SIZE-1:0] redirect_pc,
  output logic                 btb_we,
  output logic [7:0]           btb_index,
  output logic [7:0]           btb_tag,
  output logic [WORD_SIZE-1:0] btb_target,
  output logic                 upd_valid,
  output logic                 update_taken
`ifdef BR_RESOLVER_STATS_EN
  ,
  output logic [15:0]          stat_branches,
  output logic [15:0]          stat_mispredicts
`endif
);

  br_state_t            r_state;
  br_state_t            w_state_nxt;
  logic                 r_flush,  w_flush_nxt;
  logic [WORD_SIZE-1:0] r_redirect_pc, w_redirect_pc_nxt;
  logic                 r_btb_we, w_btb_we_nxt;
  logic [7:0]           r_btb_index, w_btb_index_nxt;
  logic [7:0]           r_btb_tag, w_btb_tag_nxt;
  logic [WORD_SIZE-1:0] r_btb_target, w_btb_target_nxt;
  logic                 r_upd_valid, w_upd_valid_nxt;
  logic                 r_update_taken, w_update_taken_nxt;

  logic                 w_run;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  pred_entry_t          w_push_data;
  pred_entry_t          w_head;
  logic                 w_is_br;
  logic [WORD_SIZE-1:0] w_seq_pc;
  logic [WORD_SIZE-1:0] w_correct;
  logic                 w_mispred;

  assign w_run       = (r_state == ST_RUN);
  assign fetch_ready = w_run && !w_full;
  assign w_push      = w_run && fetch_valid && !w_full;
  assign w_pop       = w_run && res_valid && !w_empty;
  assign w_push_data = '{pc: fetch_pc, pred_pc: fetch_pred_pc};

  br_pred_queue #(.DEPTH(QDEPTH)) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push),
    .pop       (w_pop),
    .clear     (!w_run),
    .push_data (w_push_data),
    .full      (w_full),
    .empty     (w_empty),
    .head      (w_head)
  );

  assign w_is_br   = is_branch(res_opcode);
  assign w_seq_pc  = w_head.pc + WORD_SIZE'(1);
  assign w_correct = (w_is_br && res_bcond) ? res_target : w_seq_pc;
  assign w_mispred = (w_correct != w_head.pred_pc);

  // Next state and next pulse values; outputs fall back to idle every cycle
  always_comb begin
    w_state_nxt        = r_state;
    w_flush_nxt        = 1'b0;
    w_redirect_pc_nxt  = '0;
    w_btb_we_nxt       = 1'b0;
    w_btb_index_nxt    = '0;
    w_btb_tag_nxt      = '0;
    w_btb_target_nxt   = BTB_INVALID;
    w_upd_valid_nxt    = 1'b0;
    w_update_taken_nxt = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_pop) begin
          if (w_mispred) begin
            w_state_nxt       = ST_FLUSH;
            w_flush_nxt       = 1'b1;
            w_redirect_pc_nxt = w_correct;
          end
          if (w_is_br) begin
            w_upd_valid_nxt    = 1'b1;
            w_update_taken_nxt = res_bcond;
          end
          // Taken branch with a stale target trains the BTB; a non-branch hit is an alias
          if (w_is_br && res_bcond && (w_head.pred_pc != res_target)) begin
            w_btb_we_nxt     = 1'b1;
            w_btb_index_nxt  = w_head.pc[7:0];
            w_btb_tag_nxt    = w_head.pc[15:8];
            w_btb_target_nxt = res_target;
          end else if (!w_is_br && w_mispred) begin
            w_btb_we_nxt     = 1'b1;
            w_btb_index_nxt  = w_head.pc[7:0];
            w_btb_tag_nxt    = w_head.pc[15:8];
            w_btb_target_nxt = BTB_INVALID;
          end
        end
      end
      ST_FLUSH: w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_RUN;
      r_flush        <= 1'b0;
      r_redirect_pc  <= '0;
      r_btb_we       <= 1'b0;
      r_btb_index    <= '0;
      r_btb_tag      <= '0;
      r_btb_target   <= BTB_INVALID;
      r_upd_valid    <= 1'b0;
      r_update_taken <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_flush        <= w_flush_nxt;
      r_redirect_pc  <= w_redirect_pc_nxt;
      r_btb_we       <= w_btb_we_nxt;
      r_btb_index    <= w_btb_index_nxt;
      r_btb_tag      <= w_btb_tag_nxt;
      r_btb_target   <= w_btb_target_nxt;
      r_upd_valid    <= w_upd_valid_nxt;
      r_update_taken <= w_update_taken_nxt;
    end
  end

  assign flush        = r_flush;
  assign redirect_pc  = r_redirect_pc;
  assign btb_we       = r_btb_we;
  assign btb_index    = r_btb_index;
  assign btb_tag      = r_btb_tag;
  assign btb_target   = r_btb_target;
  assign upd_valid    = r_upd_valid;
  assign update_taken = r_update_taken;

`ifdef BR_RESOLVER_STATS_EN
  logic [15:0] r_stat_branches;
  logic [15:0] r_stat_mispredicts;

  // Saturating event counters
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat_branches    <= '0;
      r_stat_mispredicts <= '0;
    end else if (w_pop) begin
      if (w_is_br && (r_stat_branches != 16'hFFFF))
        r_stat_branches <= r_stat_branches + 16'(1);
      if (w_mispred && (r_stat_mispredicts != 16'hFFFF))
        r_stat_mispredicts <= r_stat_mispredicts + 16'(1);
    end
  end

  assign stat_branches    = r_stat_branches;
  assign stat_mispredicts = r_stat_mispredicts;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Directed self-checking bench for branch_resolver (QDEPTH = 4).
module tb_branch_resolver;
  import opcodes_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_valid;
  logic [15:0] fetch_pc;
  logic [15:0] fetch_pred_pc;
  logic        fetch_ready;
  logic        res_valid;
  logic [3:0]  res_opcode;
  logic        res_bcond;
  logic [15:0] res_target;
  logic        flush;
  logic [15:0] redirect_pc;
  logic        btb_we;
  logic [7:0]  btb_index;
  logic [7:0]  btb_tag;
  logic [15:0] btb_target;
  logic        upd_valid;
  logic        update_taken;
`ifdef BR_RESOLVER_STATS_EN
  logic [15:0] stat_branches;
  logic [15:0] stat_mispredicts;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  branch_resolver #(.QDEPTH(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .fetch_valid   (fetch_valid),
    .fetch_pc      (fetch_pc),
    .fetch_pred_pc (fetch_pred_pc),
    .fetch_ready   (fetch_ready),
    .res_valid     (res_valid),
    .res_opcode    (res_opcode),
    .res_bcond     (res_bcond),
    .res_target    (res_target),
    .flush         (flush),
    .redirect_pc   (redirect_pc),
    .btb_we        (btb_we),
    .btb_index     (btb_index),
    .btb_tag       (btb_tag),
    .btb_target    (btb_target),
    .upd_valid     (upd_valid),
    .update_taken  (update_taken)
`ifdef BR_RESOLVER_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic fl, input logic [15:0] rpc,
                         input logic we, input logic [7:0] idx, input logic [7:0] tg,
                         input logic [15:0] tgt, input logic uv, input logic ut);
    chk({tag, ".flush"},        16'(flush),        16'(fl));
    chk({tag, ".redirect_pc"},  redirect_pc,       rpc);
    chk({tag, ".btb_we"},       16'(btb_we),       16'(we));
    chk({tag, ".btb_index"},    16'(btb_index),    16'(idx));
    chk({tag, ".btb_tag"},      16'(btb_tag),      16'(tg));
    chk({tag, ".btb_target"},   btb_target,        tgt);
    chk({tag, ".upd_valid"},    16'(upd_valid),    16'(uv));
    chk({tag, ".update_taken"}, 16'(update_taken), 16'(ut));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] pc, input logic [15:0] pred);
    fetch_valid = 1'b1; fetch_pc = pc; fetch_pred_pc = pred;
    tick();
    fetch_valid = 1'b0;
  endtask

  task automatic resolve(input logic [3:0] op, input logic bc, input logic [15:0] tgt);
    res_valid = 1'b1; res_opcode = op; res_bcond = bc; res_target = tgt;
    tick();
    res_valid = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk_out(tag, 1'b0, 16'h0000, 1'b0, 8'h00, 8'h00, 16'hFFFF, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; fetch_valid = 1'b0; fetch_pc = '0; fetch_pred_pc = '0;
    res_valid = 1'b0; res_opcode = ADD_OP; res_bcond = 1'b0; res_target = '0;
    tick(); tick();
    chk_idle("reset");
    chk("reset.fetch_ready", 16'(fetch_ready), 16'd1);
    reset = 1'b0;
    tick();

    // correctly predicted ALU op
    push(16'h0010, 16'h0011);
    resolve(ADD_OP, 1'b0, 16'h0000);
    chk_idle("add_ok");
    chk("add_ok.fetch_ready", 16'(fetch_ready), 16'd1);

    // taken BEQ with wrong target
    push(16'h0020, 16'h0021);
    resolve(BEQ_OP, 1'b1, 16'h0030);
    chk_out("beq_taken", 1'b1, 16'h0030, 1'b1, 8'h20, 8'h00, 16'h0030, 1'b1, 1'b1);
    chk("beq_taken.fetch_ready_in_flush", 16'(fetch_ready), 16'd0);
    tick();
    chk_idle("beq_taken.pulse_end");
    chk("beq_taken.fetch_ready_after", 16'(fetch_ready), 16'd1);

    // not-taken BNE predicted taken
    push(16'h1234, 16'h1240);
    resolve(BNE_OP, 1'b0, 16'h5555);
    chk_out("bne_nt", 1'b1, 16'h1235, 1'b0, 8'h00, 8'h00, 16'hFFFF, 1'b1, 1'b0);
    tick();

    // non-branch BTB alias at the top of the address space, pc+1 wraps
    push(16'hFFFF, 16'h0005);
    resolve(SUB_OP, 1'b1, 16'h1111);
    chk_out("alias_wrap", 1'b1, 16'h0000, 1'b1, 8'hFF, 8'hFF, 16'hFFFF, 1'b0, 1'b0);
    tick();

    // correctly predicted branches: counter update only
    push(16'h0040, 16'h0041);
    resolve(BGZ_OP, 1'b0, 16'h0200);
    chk_out("bgz_nt_ok", 1'b0, 16'h0000, 1'b0, 8'h00, 8'h00, 16'hFFFF, 1'b1, 1'b0);
    push(16'h0050, 16'h0100);
    resolve(BLZ_OP, 1'b1, 16'h0100);
    chk_out("blz_t_ok", 1'b0, 16'h0000, 1'b0, 8'h00, 8'h00, 16'hFFFF, 1'b1, 1'b1);

    // fill, drop when full, simultaneous push/pop, in-order drain
    push(16'h0100, 16'h0101);
    push(16'h0200, 16'h0201);
    push(16'h0300, 16'h0301);
    chk("fill3.fetch_ready", 16'(fetch_ready), 16'd1);
    push(16'h0400, 16'h0401);
    chk("full.fetch_ready", 16'(fetch_ready), 16'd0);
    push(16'h0500, 16'h0777);
    chk("drop.fetch_ready", 16'(fetch_ready), 16'd0);
    resolve(ADD_OP, 1'b0, 16'h0000);
    chk("pop1.flush", 16'(flush), 16'd0);
    chk("pop1.fetch_ready", 16'(fetch_ready), 16'd1);
    fetch_valid = 1'b1; fetch_pc = 16'h0600; fetch_pred_pc = 16'h0601;
    resolve(ADD_OP, 1'b0, 16'h0000);
    fetch_valid = 1'b0;
    chk("pushpop.flush", 16'(flush), 16'd0);
    chk("pushpop.fetch_ready", 16'(fetch_ready), 16'd1);
    push(16'h0700, 16'h0799);
    chk("refill.fetch_ready", 16'(fetch_ready), 16'd0);
    resolve(ADD_OP, 1'b0, 16'h0000);
    chk("drain_0300.flush", 16'(flush), 16'd0);
    resolve(ADD_OP, 1'b0, 16'h0000);
    chk("drain_0400.flush", 16'(flush), 16'd0);
    resolve(ADD_OP, 1'b0, 16'h0000);
    chk("drain_0600.flush", 16'(flush), 16'd0);
    resolve(ADD_OP, 1'b0, 16'h0000);
    chk_out("drain_0700", 1'b1, 16'h0701, 1'b1, 8'h00, 8'h07, 16'hFFFF, 1'b0, 1'b0);
    tick();

    // mispredict with 3 queued and a same-cycle push; FLUSH clears everything
    push(16'h0800, 16'h0855);
    push(16'h0810, 16'h0BAD);
    push(16'h0820, 16'h0BAD);
    fetch_valid = 1'b1; fetch_pc = 16'h0830; fetch_pred_pc = 16'h0CAD;
    resolve(ADD_OP, 1'b0, 16'h0000);
    fetch_valid = 1'b0;
    chk_out("squash", 1'b1, 16'h0801, 1'b1, 8'h00, 8'h08, 16'hFFFF, 1'b0, 1'b0);
    chk("squash.fetch_ready", 16'(fetch_ready), 16'd0);
    res_valid = 1'b1; res_opcode = ADD_OP; res_bcond = 1'b0; res_target = 16'h0000;
    tick();
    chk_idle("flush_cycle_ignored");
    chk("after_flush.fetch_ready", 16'(fetch_ready), 16'd1);
    tick();
    res_valid = 1'b0;
    chk_idle("empty_res_ignored");

    // reset during FLUSH suppresses pending pulses
    push(16'h0900, 16'h0000);
    resolve(ADD_OP, 1'b0, 16'h0000);
    chk("pre_reset.flush", 16'(flush), 16'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_idle("reset_in_flush");
    chk("reset_in_flush.fetch_ready", 16'(fetch_ready), 16'd1);
    tick();
    chk_idle("reset_in_flush.next");

`ifdef BR_RESOLVER_STATS_EN
    chk("stats_cleared.branches", stat_branches, 16'd0);
    chk("stats_cleared.mispredicts", stat_mispredicts, 16'd0);
    push(16'h0A00, 16'h0A01);
    resolve(BEQ_OP, 1'b1, 16'h0B00);
    tick();
    chk("stats.branches", stat_branches, 16'd1);
    chk("stats.mispredicts", stat_mispredicts, 16'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
